// File: rtl/disc_arbiter.sv
// Round-robin arbiter sharing one discriminator MAC between a real (0) and a fake (1) sample source.
// Optional WAIT-state watchdog is built when DISC_ARB_WATCHDOG_EN is defined.
module disc_arbiter #(
    parameter int DATA_W  = 4096,
    parameter int TIMEOUT = 300
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [DATA_W-1:0] req1_data,
    output logic              disc_start,
    output logic [DATA_W-1:0] disc_input,
    input  logic [15:0]       disc_score,
    input  logic              disc_decision,
    input  logic              disc_done,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_id,
    output logic [15:0]       res_score,
    output logic              res_decision,
    output logic              res_err,
    output logic [15:0]       cnt_real_ok,
    output logic [15:0]       cnt_fake_ok
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESP
    } state_t;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                id_q, id_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic [15:0]         score_q, score_d;
    logic                decision_q, decision_d;
    logic [15:0]         cnt_real_q, cnt_real_d;
    logic [15:0]         cnt_fake_q, cnt_fake_d;
    logic [1:0]          grant;

`ifdef DISC_ARB_WATCHDOG_EN
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);
    logic                err_q, err_d;
    logic [15:0]         wdog_q, wdog_d;
`else
    if (TIMEOUT < 0) begin : g_timeout_unused
    end
`endif

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant = 2'b00;
        unique case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        sample_d     = sample_q;
        score_d      = score_q;
        decision_d   = decision_q;
        cnt_real_d   = cnt_real_q;
        cnt_fake_d   = cnt_fake_q;
`ifdef DISC_ARB_WATCHDOG_EN
        err_d        = err_q;
        wdog_d       = 16'd0;
`endif
        req_ready    = 2'b00;
        disc_start   = 1'b0;
        res_valid    = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready = rst_n ? grant : 2'b00;
                if (grant != 2'b00) begin
                    id_d         = grant[1];
                    last_grant_d = grant[1];
                    sample_d     = grant[1] ? req1_data : req0_data;
                    state_d      = LAUNCH;
                end
            end
            LAUNCH: begin
                disc_start = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
`ifdef DISC_ARB_WATCHDOG_EN
                wdog_d = wdog_q + 16'd1;
`endif
                // A done arriving on the expiry cycle still counts as a normal result.
                if (disc_done) begin
                    score_d    = disc_score;
                    decision_d = disc_decision;
`ifdef DISC_ARB_WATCHDOG_EN
                    err_d      = 1'b0;
`endif
                    if (!id_q && disc_decision && (cnt_real_q != 16'hFFFF)) begin
                        cnt_real_d = cnt_real_q + 16'd1;
                    end
                    if (id_q && !disc_decision && (cnt_fake_q != 16'hFFFF)) begin
                        cnt_fake_d = cnt_fake_q + 16'd1;
                    end
                    state_d = RESP;
                end
`ifdef DISC_ARB_WATCHDOG_EN
                else if (wdog_q == WDOG_LAST) begin
                    score_d    = 16'd0;
                    decision_d = 1'b0;
                    err_d      = 1'b1;
                    state_d    = RESP;
                end
`endif
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            sample_q     <= '0;
            score_q      <= 16'd0;
            decision_q   <= 1'b0;
            cnt_real_q   <= 16'd0;
            cnt_fake_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            sample_q     <= sample_d;
            score_q      <= score_d;
            decision_q   <= decision_d;
            cnt_real_q   <= cnt_real_d;
            cnt_fake_q   <= cnt_fake_d;
        end
    end

`ifdef DISC_ARB_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q  <= 1'b0;
            wdog_q <= 16'd0;
        end else begin
            err_q  <= err_d;
            wdog_q <= wdog_d;
        end
    end

    assign res_err = err_q;
`else
    assign res_err = 1'b0;
`endif

    assign disc_input   = sample_q;
    assign res_id       = id_q;
    assign res_score    = score_q;
    assign res_decision = decision_q;
    assign cnt_real_ok  = cnt_real_q;
    assign cnt_fake_ok  = cnt_fake_q;

endmodule

// File: tb/tb_disc_arbiter.sv
// Directed self-checking bench for disc_arbiter with a behavioural MAC model of configurable latency.
module tb_disc_arbiter;
    localparam int DATA_W  = 4096;
    localparam int TIMEOUT = 300;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        req_valid = 2'b00;
    logic [1:0]        req_ready;
    logic [DATA_W-1:0] req0_data;
    logic [DATA_W-1:0] req1_data;
    logic              disc_start;
    logic [DATA_W-1:0] disc_input;
    logic [15:0]       disc_score;
    logic              disc_decision;
    logic              disc_done;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic              res_id;
    logic [15:0]       res_score;
    logic              res_decision;
    logic              res_err;
    logic [15:0]       cnt_real_ok;
    logic [15:0]       cnt_fake_ok;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int          mac_cnt = 0;
    int          mac_lat = 5;
    logic        mac_en = 1'b1;
    logic        mac_done = 1'b0;
    logic        spur_done = 1'b0;
    logic [15:0] mac_score = 16'd0;
    logic        mac_dec = 1'b0;

    int   start_hi = 0;
    int   start_pulses = 0;
    logic start_prev = 1'b0;

    assign disc_done     = mac_done | spur_done;
    assign disc_score    = mac_score;
    assign disc_decision = mac_dec;

    disc_arbiter #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_data(req0_data), .req1_data(req1_data),
        .disc_start(disc_start), .disc_input(disc_input),
        .disc_score(disc_score), .disc_decision(disc_decision), .disc_done(disc_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_score(res_score), .res_decision(res_decision), .res_err(res_err),
        .cnt_real_ok(cnt_real_ok), .cnt_fake_ok(cnt_fake_ok)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // MAC model: done is high mac_lat cycles after the cycle carrying disc_start.
    always @(negedge clk) begin
        if (!rst_n) begin
            mac_cnt  <= 0;
            mac_done <= 1'b0;
        end else if (mac_cnt > 1) begin
            mac_cnt  <= mac_cnt - 1;
            mac_done <= 1'b0;
        end else if (mac_cnt == 1) begin
            mac_cnt  <= 0;
            mac_done <= 1'b1;
        end else begin
            mac_done <= 1'b0;
            if (disc_start && mac_en) mac_cnt <= mac_lat;
        end
    end

    always @(negedge clk) begin
        start_hi     <= start_hi + (disc_start ? 1 : 0);
        start_pulses <= start_pulses + ((disc_start && !start_prev) ? 1 : 0);
        start_prev   <= disc_start;
    end

    task automatic wait_ready(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            #1;
            if (req_ready != 2'b00) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL grant_timeout: req_ready=%b after %0d cycles, required a grant", req_ready, limit);
        end
    endtask

    task automatic do_accept(input logic [1:0] v, output bit id, output int t);
        bit ok;
        req_valid = v;
        wait_ready(50, ok);
        id = req_ready[1];
        @(negedge clk);
        t = cyc;
        req_valid = 2'b00;
    endtask

    task automatic wait_res(input int limit, output int seen);
        seen = -1;
        for (int i = 0; i < limit; i++) begin
            if (res_valid === 1'b1) begin
                seen = cyc;
                break;
            end
            @(negedge clk);
        end
        if (seen < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL result_timeout: res_valid never rose within %0d cycles, required 1", limit);
        end
    endtask

    task automatic release_res();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req_valid = 2'b11;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_req_ready: got %b required 00", req_ready); end
        checks++; if (disc_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_disc_start: got %b required 0", disc_start); end
        checks++; if (disc_input !== '0) begin errors++; $display("[TB] FAIL reset_disc_input: got nonzero required 0"); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_valid: got %b required 0", res_valid); end
        checks++; if (res_id !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_id: got %b required 0", res_id); end
        checks++; if (res_score !== 16'h0000) begin errors++; $display("[TB] FAIL reset_res_score: got %h required 0000", res_score); end
        checks++; if (res_decision !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_decision: got %b required 0", res_decision); end
        checks++; if (res_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_err: got %b required 0", res_err); end
        checks++; if (cnt_real_ok !== 16'h0000) begin errors++; $display("[TB] FAIL reset_cnt_real: got %h required 0000", cnt_real_ok); end
        checks++; if (cnt_fake_ok !== 16'h0000) begin errors++; $display("[TB] FAIL reset_cnt_fake: got %h required 0000", cnt_fake_ok); end
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL reset_first_tie: got %b required 01", req_ready); end
        req_valid = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_single_real();
        bit id;
        int t, seen;
        mac_en = 1'b1; mac_lat = 257; mac_score = 16'h0140; mac_dec = 1'b1;
        res_ready = 1'b1;
        do_accept(2'b01, id, t);
        checks++; if (id !== 1'b0) begin errors++; $display("[TB] FAIL single_grant: got %b required 0", id); end
        checks++; if (disc_start !== 1'b1) begin errors++; $display("[TB] FAIL single_start_T1: got %b required 1", disc_start); end
        checks++; if (disc_input !== req0_data) begin errors++; $display("[TB] FAIL single_disc_input: low word %h required %h", disc_input[15:0], req0_data[15:0]); end
        @(negedge clk);
        checks++; if (disc_start !== 1'b0) begin errors++; $display("[TB] FAIL single_start_width: got %b required 0", disc_start); end
        wait_res(400, seen);
        checks++; if (seen != t + 258) begin errors++; $display("[TB] FAIL single_latency: res_valid in cycle offset %0d required 259", seen - t + 1); end
        checks++; if (res_id !== 1'b0) begin errors++; $display("[TB] FAIL single_res_id: got %b required 0", res_id); end
        checks++; if (res_score !== 16'h0140) begin errors++; $display("[TB] FAIL single_res_score: got %h required 0140", res_score); end
        checks++; if (res_decision !== 1'b1) begin errors++; $display("[TB] FAIL single_res_decision: got %b required 1", res_decision); end
        checks++; if (res_err !== 1'b0) begin errors++; $display("[TB] FAIL single_res_err: got %b required 0", res_err); end
        checks++; if (cnt_real_ok !== 16'd1) begin errors++; $display("[TB] FAIL single_cnt_real: got %h required 0001", cnt_real_ok); end
        checks++; if (cnt_fake_ok !== 16'd0) begin errors++; $display("[TB] FAIL single_cnt_fake: got %h required 0000", cnt_fake_ok); end
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL single_ready_in_resp: got %b required 00", req_ready); end
        @(negedge clk);
        #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_res_clear: got %b required 0", res_valid); end
        checks++; if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL single_next_ready_T260: got %b required 01", req_ready); end
        req_valid = 2'b00;
        res_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        bit ok, exp;
        int seen, p0, h0;
        do_reset();
        mac_en = 1'b1; mac_lat = 5; mac_score = 16'h0010; mac_dec = 1'b1;
        res_ready = 1'b1;
        #1;
        p0 = start_pulses;
        h0 = start_hi;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp = i[0];
            wait_ready(50, ok);
            checks++; if (req_ready !== (exp ? 2'b10 : 2'b01)) begin errors++; $display("[TB] FAIL rr_grant_%0d: got %b required %b", i, req_ready, exp ? 2'b10 : 2'b01); end
            @(negedge clk);
            checks++; if (disc_input !== (exp ? req1_data : req0_data)) begin errors++; $display("[TB] FAIL rr_sample_%0d: low word %h required %h", i, disc_input[15:0], exp ? req1_data[15:0] : req0_data[15:0]); end
            wait_res(50, seen);
            checks++; if (res_id !== exp) begin errors++; $display("[TB] FAIL rr_res_id_%0d: got %b required %b", i, res_id, exp); end
            if (i == 3) req_valid = 2'b00;
        end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (start_pulses - p0 != 4) begin errors++; $display("[TB] FAIL rr_start_pulses: got %0d required 4", start_pulses - p0); end
        checks++; if (start_hi - h0 != 4) begin errors++; $display("[TB] FAIL rr_start_high_cycles: got %0d required 4", start_hi - h0); end
        checks++; if (cnt_real_ok !== 16'd2) begin errors++; $display("[TB] FAIL rr_cnt_real: got %h required 0002", cnt_real_ok); end
        checks++; if (cnt_fake_ok !== 16'd0) begin errors++; $display("[TB] FAIL rr_cnt_fake: got %h required 0000", cnt_fake_ok); end
        res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bit id;
        int t, seen, p0, bad;
        mac_en = 1'b1; mac_lat = 5; mac_score = 16'hFF00; mac_dec = 1'b0;
        res_ready = 1'b0;
        @(negedge clk);
        do_accept(2'b10, id, t);
        checks++; if (id !== 1'b1) begin errors++; $display("[TB] FAIL bp_grant: got %b required 1", id); end
        wait_res(50, seen);
        #1;
        p0 = start_pulses;
        bad = 0;
        req_valid = 2'b11;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (res_valid !== 1'b1 || res_score !== 16'hFF00 || res_id !== 1'b1 ||
                res_decision !== 1'b0 || req_ready !== 2'b00 || disc_start !== 1'b0) bad++;
            @(negedge clk);
        end
        #1;
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL bp_hold_stable: %0d unstable cycles required 0", bad); end
        checks++; if (start_pulses != p0) begin errors++; $display("[TB] FAIL bp_no_start: %0d extra pulses required 0", start_pulses - p0); end
        res_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release_valid: got %b required 0", res_valid); end
        checks++; if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL bp_release_idle: got %b required 01", req_ready); end
        req_valid = 2'b00;
        res_ready = 1'b0;
        checks++; if (cnt_fake_ok !== 16'd1) begin errors++; $display("[TB] FAIL bp_cnt_fake: got %h required 0001", cnt_fake_ok); end
        checks++; if (cnt_real_ok !== 16'd2) begin errors++; $display("[TB] FAIL bp_cnt_real: got %h required 0002", cnt_real_ok); end
        @(negedge clk);
    endtask

    task automatic run_txn(input logic [1:0] v, input logic [15:0] sc, input logic dec);
        bit id;
        int t, seen;
        mac_en = 1'b1; mac_lat = 5; mac_score = sc; mac_dec = dec;
        do_accept(v, id, t);
        wait_res(50, seen);
    endtask

    task automatic test_spurious();
        do_reset();
        mac_score = 16'h7FFF; mac_dec = 1'b1; spur_done = 1'b1;
        @(negedge clk);
        mac_dec = 1'b0;
        @(negedge clk);
        spur_done = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL spur_idle_valid: got %b required 0", res_valid); end
        checks++; if (res_score !== 16'h0000) begin errors++; $display("[TB] FAIL spur_idle_score: got %h required 0000", res_score); end
        checks++; if (cnt_real_ok !== 16'd0 || cnt_fake_ok !== 16'd0) begin errors++; $display("[TB] FAIL spur_idle_counters: got %h/%h required 0000/0000", cnt_real_ok, cnt_fake_ok); end
        @(negedge clk);
        run_txn(2'b10, 16'hFE80, 1'b0);
        checks++; if (res_score !== 16'hFE80) begin errors++; $display("[TB] FAIL spur_fake_score: got %h required FE80", res_score); end
        checks++; if (cnt_fake_ok !== 16'd1) begin errors++; $display("[TB] FAIL spur_cnt_fake: got %h required 0001", cnt_fake_ok); end
        checks++; if (cnt_real_ok !== 16'd0) begin errors++; $display("[TB] FAIL spur_cnt_real: got %h required 0000", cnt_real_ok); end
        mac_score = 16'h1111; mac_dec = 1'b1; spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (res_score !== 16'hFE80 || res_decision !== 1'b0) begin errors++; $display("[TB] FAIL spur_resp_hold: got %h/%b required FE80/0", res_score, res_decision); end
        checks++; if (cnt_fake_ok !== 16'd1) begin errors++; $display("[TB] FAIL spur_resp_cnt: got %h required 0001", cnt_fake_ok); end
        release_res();
        force dut.cnt_fake_q = 16'hFFFE;
        @(negedge clk);
        release dut.cnt_fake_q;
        #1;
        checks++; if (cnt_fake_ok !== 16'hFFFE) begin errors++; $display("[TB] FAIL sat_preset: got %h required FFFE", cnt_fake_ok); end
        @(negedge clk);
        run_txn(2'b10, 16'h0001, 1'b0);
        checks++; if (cnt_fake_ok !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_reach: got %h required FFFF", cnt_fake_ok); end
        release_res();
        run_txn(2'b10, 16'h0002, 1'b0);
        checks++; if (cnt_fake_ok !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_hold: got %h required FFFF", cnt_fake_ok); end
        release_res();
        run_txn(2'b01, 16'h0003, 1'b0);
        checks++; if (cnt_real_ok !== 16'd0 || cnt_fake_ok !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_real_wrong: got %h/%h required 0000/FFFF", cnt_real_ok, cnt_fake_ok); end
        release_res();
    endtask

`ifdef DISC_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        bit id;
        int t, seen;
        do_reset();
        mac_en = 1'b0; res_ready = 1'b0;
        do_accept(2'b01, id, t);
        wait_res(400, seen);
        checks++; if (seen != t + 301) begin errors++; $display("[TB] FAIL wd_expiry: %0d WAIT cycles required 300", seen - t - 1); end
        checks++; if (res_err !== 1'b1) begin errors++; $display("[TB] FAIL wd_err: got %b required 1", res_err); end
        checks++; if (res_score !== 16'h0000 || res_decision !== 1'b0) begin errors++; $display("[TB] FAIL wd_result: got %h/%b required 0000/0", res_score, res_decision); end
        checks++; if (cnt_real_ok !== 16'd0 || cnt_fake_ok !== 16'd0) begin errors++; $display("[TB] FAIL wd_counters: got %h/%h required 0000/0000", cnt_real_ok, cnt_fake_ok); end
        release_res();
        mac_en = 1'b1; mac_lat = 300; mac_score = 16'h0200; mac_dec = 1'b1;
        do_accept(2'b01, id, t);
        wait_res(400, seen);
        checks++; if (seen != t + 301) begin errors++; $display("[TB] FAIL wd_tie_latency: %0d WAIT cycles required 300", seen - t - 1); end
        checks++; if (res_err !== 1'b0 || res_score !== 16'h0200) begin errors++; $display("[TB] FAIL wd_tie_result: got err %b score %h required 0/0200", res_err, res_score); end
        checks++; if (cnt_real_ok !== 16'd1) begin errors++; $display("[TB] FAIL wd_tie_cnt: got %h required 0001", cnt_real_ok); end
        release_res();
    endtask
`else
    task automatic test_watchdog();
        bit id;
        int t, bad;
        do_reset();
        mac_en = 1'b0; res_ready = 1'b0;
        do_accept(2'b01, id, t);
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            if (res_valid !== 1'b0 || res_err !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL nowd_wait_forever: %0d cycles with result required 0", bad); end
        do_reset();
    endtask
`endif

    task automatic test_reset_in_wait();
        bit id;
        int t;
        @(negedge clk);
        run_txn(2'b10, 16'h0A0A, 1'b0);
        release_res();
        mac_en = 1'b0;
        do_accept(2'b01, id, t);
        repeat (20) @(negedge clk);
        req_valid = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b00 || disc_start !== 1'b0) begin errors++; $display("[TB] FAIL rst_wait_ctrl: ready %b start %b required 00/0", req_ready, disc_start); end
        checks++; if (disc_input !== '0) begin errors++; $display("[TB] FAIL rst_wait_input: low word %h required 0", disc_input[15:0]); end
        checks++; if (res_valid !== 1'b0 || res_id !== 1'b0 || res_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_wait_res: valid %b id %b err %b required 0/0/0", res_valid, res_id, res_err); end
        checks++; if (res_score !== 16'h0000 || res_decision !== 1'b0) begin errors++; $display("[TB] FAIL rst_wait_score: got %h/%b required 0000/0", res_score, res_decision); end
        checks++; if (cnt_real_ok !== 16'd0 || cnt_fake_ok !== 16'd0) begin errors++; $display("[TB] FAIL rst_wait_counters: got %h/%h required 0000/0000", cnt_real_ok, cnt_fake_ok); end
        @(negedge clk);
        rst_n = 1'b1;
        mac_en = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL rst_wait_tie: got %b required 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        checks++; if (disc_start !== 1'b1 || disc_input !== req0_data) begin errors++; $display("[TB] FAIL rst_wait_relaunch: start %b low word %h required 1/%h", disc_start, disc_input[15:0], req0_data[15:0]); end
        repeat (10) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            req0_data[i*16 +: 16] = 16'hA500 + 16'(i);
            req1_data[i*16 +: 16] = 16'h5A00 ^ 16'(i * 3);
        end
        test_reset();
        test_single_real();
        test_round_robin();
        test_backpressure();
        test_spurious();
        test_watchdog();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
